// File: rtl/efuse_ctrl_pkg.sv
// rtl/efuse_ctrl_pkg.sv - shared FSM state codes, macro pin modes and helpers for the eFuse sequencer
package efuse_ctrl_pkg;

  localparam logic [2:0] ST_BOOT   = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_PWR_UP = 3'd2;
  localparam logic [2:0] ST_SETUP  = 3'd3;
  localparam logic [2:0] ST_STRB   = 3'd4;
  localparam logic [2:0] ST_HOLD   = 3'd5;
  localparam logic [2:0] ST_PWR_DN = 3'd6;
  localparam logic [2:0] ST_ACK    = 3'd7;

  typedef struct packed {
    logic csb;
    logic load;
    logic pgenb;
    logic vddq;
  } pin_mode_t;

  localparam pin_mode_t MODE_IDLE = 4'b1010;
  localparam pin_mode_t MODE_READ = 4'b0110;
  localparam pin_mode_t MODE_PGM  = 4'b0001;
  // Programming supply ramp: VDDQ up while the macro is still deselected
  localparam pin_mode_t MODE_VDDQ = 4'b1011;

  function automatic int max_int(input int a, input int b);
    max_int = (a > b) ? a : b;
  endfunction

  function automatic pin_mode_t mode_for(input logic [2:0] st, input logic wr);
    case (st)
      ST_PWR_UP, ST_PWR_DN:        mode_for = MODE_VDDQ;
      ST_SETUP, ST_STRB, ST_HOLD:  mode_for = wr ? MODE_PGM : MODE_READ;
      default:                     mode_for = MODE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/efuse_ctrl_if.sv
// rtl/efuse_ctrl_if.sv - host request/acknowledge bus between register block and eFuse sequencer
interface efuse_ctrl_if;
  logic       req;
  logic       req_wr;
  logic [6:0] req_addr;
  logic [2:0] req_bit;
  logic       ack;
  logic       err;
  logic [7:0] rdata;

  modport master (
    output req, req_wr, req_addr, req_bit,
    input  ack, err, rdata
  );

  modport slave (
    input  req, req_wr, req_addr, req_bit,
    output ack, err, rdata
  );
endinterface

// File: rtl/efuse_phase_timer.sv
// rtl/efuse_phase_timer.sv - loadable down-counter timing each macro access phase
module efuse_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  // Loading N-1 keeps the owning state alive for exactly N cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/efuse_ctrl.sv
// rtl/efuse_ctrl.sv - eFuse sequencer: boot shadow load, host byte reads and bit programs
module efuse_ctrl
  import efuse_ctrl_pkg::*;
#(
  parameter int NUM_BYTES  = 10,
  parameter int T_SETUP    = 2,
  parameter int T_STRB_RD  = 2,
  parameter int T_STRB_PGM = 8,
  parameter int T_HOLD     = 2,
  parameter int T_VDDQ     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  efuse_ctrl_if.slave            bus,
  input  logic                   pgm_lock_i,
  output logic                   boot_done_o,
  output logic [8*NUM_BYTES-1:0] shadow_o,
  output logic                   efuse_csb_o,
  output logic                   efuse_strobe_o,
  output logic                   efuse_load_o,
  output logic                   efuse_pgenb_o,
  output logic                   efuse_vddq_o,
  output logic [9:0]             efuse_a_o,
  input  logic [7:0]             efuse_q_i
);

  localparam int T_MAX = max_int(max_int(max_int(T_SETUP, T_STRB_RD), max_int(T_STRB_PGM, T_HOLD)), T_VDDQ);
  localparam int TW    = $clog2(T_MAX + 1);

  localparam logic [TW-1:0] L_SETUP = TW'(T_SETUP - 1);
  localparam logic [TW-1:0] L_RD    = TW'(T_STRB_RD - 1);
  localparam logic [TW-1:0] L_PGM   = TW'(T_STRB_PGM - 1);
  localparam logic [TW-1:0] L_HOLD  = TW'(T_HOLD - 1);
  localparam logic [TW-1:0] L_VDDQ  = TW'(T_VDDQ - 1);
  localparam logic [6:0]    LAST_IDX = 7'(NUM_BYTES - 1);

  logic [2:0]             r_state, w_state_nxt;
  logic [6:0]             r_idx;
  logic [6:0]             r_addr, w_addr_nxt;
  logic [2:0]             r_bit, w_bit_nxt;
  logic                   r_wr, w_wr_nxt;
  logic                   r_err, w_err_nxt;
  logic                   r_boot_done;
  logic                   r_ack, r_err_o;
  logic [7:0]             r_rdata;
  logic [8*NUM_BYTES-1:0] r_shadow;
  pin_mode_t              r_mode;
  logic                   r_strobe;
  logic [9:0]             r_a;
  logic                   w_done, w_load, w_start, w_capture;
  logic [TW-1:0]          w_load_val;

  efuse_phase_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_val  (w_load_val),
    .o_done (w_done)
  );

  // IDLE is only reachable after boot, so host requests are naturally ignored until then
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_bit_nxt   = r_bit;
    w_wr_nxt    = r_wr;
    w_err_nxt   = r_err;
    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_SETUP;
        w_addr_nxt  = r_idx;
        w_bit_nxt   = 3'd0;
        w_wr_nxt    = 1'b0;
        w_err_nxt   = 1'b0;
      end
      ST_IDLE: begin
        if (bus.req) begin
          w_addr_nxt = bus.req_addr;
          w_bit_nxt  = bus.req_bit;
          w_wr_nxt   = bus.req_wr;
          w_err_nxt  = bus.req_wr & pgm_lock_i;
          if (!bus.req_wr)    w_state_nxt = ST_SETUP;
          else if (pgm_lock_i) w_state_nxt = ST_ACK;
          else                 w_state_nxt = ST_PWR_UP;
        end
      end
      ST_PWR_UP: if (w_done) w_state_nxt = ST_SETUP;
      ST_SETUP:  if (w_done) w_state_nxt = ST_STRB;
      ST_STRB:   if (w_done) w_state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (w_done) begin
          if (!r_boot_done) w_state_nxt = (r_idx == LAST_IDX) ? ST_IDLE : ST_BOOT;
          else              w_state_nxt = r_wr ? ST_PWR_DN : ST_ACK;
        end
      end
      ST_PWR_DN: if (w_done) w_state_nxt = ST_ACK;
      ST_ACK:    w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    case (w_state_nxt)
      ST_PWR_UP, ST_PWR_DN: w_load_val = L_VDDQ;
      ST_SETUP:             w_load_val = L_SETUP;
      ST_STRB:              w_load_val = r_wr ? L_PGM : L_RD;
      ST_HOLD:              w_load_val = L_HOLD;
      default:              w_load_val = '0;
    endcase
  end

  assign w_load    = (w_state_nxt != r_state);
  assign w_start   = ((r_state == ST_BOOT) || (r_state == ST_IDLE)) &&
                     ((w_state_nxt == ST_SETUP) || (w_state_nxt == ST_PWR_UP));
  assign w_capture = (r_state == ST_STRB) && w_done && !r_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_BOOT;
      r_idx       <= 7'd0;
      r_addr      <= 7'd0;
      r_bit       <= 3'd0;
      r_wr        <= 1'b0;
      r_err       <= 1'b0;
      r_boot_done <= 1'b0;
      r_ack       <= 1'b0;
      r_err_o     <= 1'b0;
      r_rdata     <= 8'd0;
      r_shadow    <= '0;
      r_mode      <= MODE_IDLE;
      r_strobe    <= 1'b0;
      r_a         <= 10'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_addr   <= w_addr_nxt;
      r_bit    <= w_bit_nxt;
      r_wr     <= w_wr_nxt;
      r_err    <= w_err_nxt;
      r_ack    <= (r_state == ST_ACK);
      r_err_o  <= (r_state == ST_ACK) && r_err;
      // Pins follow the next state so they switch on the same edge as the FSM
      r_mode   <= mode_for(w_state_nxt, w_wr_nxt);
      r_strobe <= (w_state_nxt == ST_STRB);
      if (w_start) begin
        r_a <= {(w_wr_nxt ? w_bit_nxt : 3'd0), w_addr_nxt};
      end
      if (w_capture) begin
        if (r_boot_done) r_rdata <= efuse_q_i;
        for (int i = 0; i < NUM_BYTES; i++) begin
          if (r_addr == 7'(i)) r_shadow[8*i +: 8] <= efuse_q_i;
        end
      end
      if ((r_state == ST_HOLD) && w_done && !r_boot_done) begin
        if (r_idx == LAST_IDX) r_boot_done <= 1'b1;
        else                   r_idx       <= r_idx + 7'd1;
      end
    end
  end

  assign bus.ack        = r_ack;
  assign bus.err        = r_err_o;
  assign bus.rdata      = r_rdata;
  assign boot_done_o    = r_boot_done;
  assign shadow_o       = r_shadow;
  assign efuse_csb_o    = r_mode.csb;
  assign efuse_load_o   = r_mode.load;
  assign efuse_pgenb_o  = r_mode.pgenb;
  assign efuse_vddq_o   = r_mode.vddq;
  assign efuse_strobe_o = r_strobe;
  assign efuse_a_o      = r_a;

endmodule

// File: tb/tb_efuse_ctrl.sv
// tb/tb_efuse_ctrl.sv - directed bench for efuse_ctrl with a behavioural 128x8 eFuse macro
module tb_efuse_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pgm_lock = 1'b0;
  logic        boot_done;
  logic [79:0] shadow;
  logic        csb, strobe, load, pgenb, vddq;
  logic [9:0]  a;
  logic [7:0]  q;

  always #5 clk = ~clk;

  efuse_ctrl_if bus ();

  efuse_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .pgm_lock_i     (pgm_lock),
    .boot_done_o    (boot_done),
    .shadow_o       (shadow),
    .efuse_csb_o    (csb),
    .efuse_strobe_o (strobe),
    .efuse_load_o   (load),
    .efuse_pgenb_o  (pgenb),
    .efuse_vddq_o   (vddq),
    .efuse_a_o      (a),
    .efuse_q_i      (q)
  );

  logic [7:0] mem [128];
  assign q = (!csb && load) ? mem[a[6:0]] : 8'h00;

  always @(posedge clk) begin
    if (rst_n && strobe && !csb && !pgenb && vddq) mem[a[6:0]][a[9:7]] <= 1'b1;
  end

  int n_cmp = 0, n_fail = 0;
  int s_run = 0, n_pulse = 0, n_len2 = 0, n_len8 = 0;
  int v_run = 0, v_pre = 0, v_post = 0, n_win = 0, n_access = 0;
  int bad_strobe = 0, bad_mode = 0;
  logic prev_csb = 1'b1, prev_vddq = 1'b0;

  always @(negedge clk) begin
    if (strobe) s_run++;
    else if (s_run != 0) begin
      n_pulse++;
      if (s_run == 2) n_len2++;
      else if (s_run == 8) n_len8++;
      s_run = 0;
    end
    if (!csb && prev_csb) begin n_access++; v_pre = v_run; v_run = 0; end
    if (vddq && csb) v_run++;
    if (!vddq && prev_vddq) begin v_post = v_run; v_run = 0; n_win++; end
    if (strobe && csb) bad_strobe++;
    if (!csb && (load ? (!pgenb || vddq) : (pgenb || !vddq))) bad_mode++;
    prev_csb  = csb;
    prev_vddq = vddq;
  end

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.ack && n < 100);
    check("ack_seen", bus.ack, 1'b1);
  endtask

  task automatic wait_boot();
    int c = 0;
    while (!boot_done && c < 300) begin
      @(posedge clk); #1;
      c++;
    end
    check("boot_done", boot_done, 1'b1);
  endtask

  typedef struct {
    logic       wr;
    logic [6:0] addr;
    logic [2:0] bitn;
    logic       lock;
    logic       exp_err;
    logic [7:0] exp_rd;
    int         exp_lat;
    int         sh_byte;
    logic [7:0] sh_val;
  } vec_t;

  localparam logic [79:0] BOOT_IMG = 80'h00FF00FFFF00FF00FF00;

  vec_t vec [12];
  int   lat, n, p0, l2, l8, ac0, w0;
  logic prev_s;

  initial begin
    vec[0]  = '{1'b0, 7'd3,   3'd0, 1'b0, 1'b0, 8'hFF, 7,  3, 8'hFF};
    vec[1]  = '{1'b1, 7'd0,   3'd3, 1'b0, 1'b0, 8'h00, 21, 0, 8'h00};
    vec[2]  = '{1'b0, 7'd0,   3'd0, 1'b0, 1'b0, 8'h08, 7,  0, 8'h08};
    vec[3]  = '{1'b1, 7'd2,   3'd0, 1'b1, 1'b1, 8'h00, 1,  2, 8'h00};
    vec[4]  = '{1'b0, 7'd2,   3'd0, 1'b0, 1'b0, 8'h00, 7,  2, 8'h00};
    vec[5]  = '{1'b0, 7'd127, 3'd0, 1'b0, 1'b0, 8'h5A, 7,  9, 8'h00};
    vec[6]  = '{1'b1, 7'd127, 3'd7, 1'b0, 1'b0, 8'h00, 21, 9, 8'h00};
    vec[7]  = '{1'b0, 7'd127, 3'd0, 1'b0, 1'b0, 8'hDA, 7,  9, 8'h00};
    vec[8]  = '{1'b1, 7'd9,   3'd1, 1'b0, 1'b0, 8'h00, 21, 9, 8'h00};
    vec[9]  = '{1'b0, 7'd9,   3'd0, 1'b0, 1'b0, 8'h02, 7,  9, 8'h02};
    vec[10] = '{1'b0, 7'd64,  3'd0, 1'b0, 1'b0, 8'hC3, 7,  5, 8'hFF};
    vec[11] = '{1'b1, 7'd5,   3'd7, 1'b1, 1'b1, 8'h00, 1,  5, 8'hFF};

    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[1] = 8'hFF; mem[3] = 8'hFF; mem[5] = 8'hFF; mem[6] = 8'hFF; mem[8] = 8'hFF;
    mem[64] = 8'hC3; mem[127] = 8'h5A;
    bus.req = 1'b0; bus.req_wr = 1'b0; bus.req_addr = 7'd0; bus.req_bit = 3'd0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_pins", {csb, strobe, load, pgenb, vddq}, 5'b10010);
    check("rst_a", a, 10'd0);
    check("rst_shadow", shadow, 80'd0);
    check("rst_outs", {boot_done, bus.ack, bus.err, bus.rdata}, 11'd0);

    // Full boot load
    @(negedge clk); rst_n = 1'b1;
    wait_boot();
    check("boot_shadow", shadow, BOOT_IMG);
    check("boot_pulses", n_pulse, 10);
    check("boot_len2", n_len2, 10);
    check("boot_access", n_access, 10);

    // Reset during the STRB phase of boot index 4, then a clean reboot
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    n = 0; prev_s = 1'b0;
    for (int c = 0; c < 200 && n < 5; c++) begin
      @(negedge clk);
      if (strobe && !prev_s) n++;
      prev_s = strobe;
    end
    check("mid_boot_strb", n, 5);
    check("mid_boot_partial", shadow[31:0], 32'hFF00FF00);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_pins", {csb, strobe, load, pgenb, vddq}, 5'b10010);
    check("mid_rst_shadow", shadow, 80'd0);
    check("mid_rst_done", boot_done, 1'b0);
    @(negedge clk); @(negedge clk);
    p0 = n_pulse; l2 = n_len2; ac0 = n_access;
    rst_n = 1'b1;
    wait_boot();
    check("reboot_shadow", shadow, BOOT_IMG);
    check("reboot_pulses", n_pulse - p0, 10);
    check("reboot_len2", n_len2 - l2, 10);
    check("reboot_access", n_access - ac0, 10);

    // Host request vectors
    for (int i = 0; i < 12; i++) begin
      p0 = n_pulse; l2 = n_len2; l8 = n_len8; ac0 = n_access; w0 = n_win;
      @(negedge clk);
      bus.req = 1'b1; bus.req_wr = vec[i].wr; bus.req_addr = vec[i].addr;
      bus.req_bit = vec[i].bitn; pgm_lock = vec[i].lock;
      wait_ack(n);
      lat = n - 1;
      bus.req = 1'b0;
      bus.req_addr = ~vec[i].addr;
      check($sformatf("v%0d_lat", i), lat, vec[i].exp_lat);
      check($sformatf("v%0d_err", i), bus.err, vec[i].exp_err);
      if (!vec[i].wr) begin
        check($sformatf("v%0d_rdata", i), bus.rdata, vec[i].exp_rd);
        check($sformatf("v%0d_rd_strb", i), n_len2 - l2, 1);
      end
      if (vec[i].wr && !vec[i].lock) begin
        check($sformatf("v%0d_pgm_strb", i), n_len8 - l8, 1);
        check($sformatf("v%0d_vddq_win", i), n_win - w0, 1);
        check($sformatf("v%0d_vddq_pre", i), v_pre, 4);
        check($sformatf("v%0d_vddq_post", i), v_post, 4);
      end
      check($sformatf("v%0d_access", i), n_access - ac0, (vec[i].wr && vec[i].lock) ? 0 : 1);
      if (vec[i].lock) check($sformatf("v%0d_no_strb", i), n_pulse - p0, 0);
      check($sformatf("v%0d_shadow", i), shadow[8*vec[i].sh_byte +: 8], vec[i].sh_val);
      pgm_lock = 1'b0;
      @(posedge clk); #1;
      check($sformatf("v%0d_ack_1cyc", i), bus.ack, 1'b0);
    end

    // Back-to-back reads with req held through the first ack
    ac0 = n_access;
    @(negedge clk);
    bus.req = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 7'd1; bus.req_bit = 3'd0;
    wait_ack(n);
    check("b2b_lat1", n - 1, 7);
    check("b2b_rdata1", bus.rdata, 8'hFF);
    bus.req_addr = 7'd7;
    wait_ack(n);
    check("b2b_gap", n, 8);
    check("b2b_rdata2", bus.rdata, 8'h00);
    bus.req = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("b2b_access", n_access - ac0, 2);
    check("b2b_no_ack", bus.ack, 1'b0);

    check("strobe_vs_csb", bad_strobe, 0);
    check("pin_modes", bad_mode, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
